// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t    : FSM encoding (IDLE, SHIFT, DONE)
//   cnt_width(): width of the bit counter for a W-bit operand
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter only needs to reach W-1, so $clog2(W) bits suffice for W >= 2.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub4_fullsub.sv
// Single-bit full subtractor cell.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d         : difference bit a - b - bin
//   bout      : borrow-out
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through one full-subtractor cell. Result is {borrow_out, difference}.
// Optional macro SUB_OVF_EN adds a registered signed-overflow flag.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : request a new operation (accepted in IDLE or DONE only)
//   a, b, bin  : W-bit unsigned operands and borrow-in
//   busy       : high while bits are being computed
//   done       : one-cycle pulse when Diff is updated
//   Diff       : {borrow_out, difference[W-1:0]}, held until next completion
//   ovf        : signed overflow flag (SUB_OVF_EN only)
module serial_sub4
  import serial_sub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
`ifdef SUB_OVF_EN
  output logic         ovf,
`endif
  output logic [W:0]   Diff
);

  localparam int CW = cnt_width(W);

  state_t        state, state_nxt;
  logic [W-1:0]  a_sh, b_sh, diff_sh;
  logic          brw;
  logic [CW-1:0] cnt;
  logic          d_bit, bout_bit;
  logic          accept, last_bit;

  fullsubtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // A new operation may start from IDLE or directly out of DONE.
  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (state == SHIFT) && (cnt == CW'(W - 1));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath: operands shift right, difference bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      Diff    <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      diff_sh <= '0;
      brw     <= bin;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= {d_bit, diff_sh[W-1:1]};
      brw     <= bout_bit;
      cnt     <= cnt + 1'b1;
      // The final bit is still on d_bit this cycle, so assemble it directly.
      if (last_bit) Diff <= {bout_bit, d_bit, diff_sh[W-1:1]};
    end
  end

`ifdef SUB_OVF_EN
  // Operand sign bits are shifted out of a_sh/b_sh, so keep them separately.
  logic a_msb, b_msb;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[W-1];
      b_msb <= b[W-1];
    end else if (last_bit) begin
      ovf <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub4.sv
module tb_serial_sub4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W:0]   Diff;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_sub4 #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef SUB_OVF_EN
    .ovf   (ovf),
`endif
    .Diff  (Diff)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W:0]   diff;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_result(input string name, input logic [W:0] ed, input logic eo);
    check({name, " done"}, int'(done), 1);
    check({name, " busy@done"}, int'(busy), 0);
    check({name, " Diff"}, int'(Diff), int'(ed));
`ifdef SUB_OVF_EN
    check({name, " ovf"}, int'(ovf), int'(eo));
`endif
  endtask

  // Called on a negedge: drive start for the coming edge (cycle 0).
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
    a = va; b = vb; bin = vbin; start = 1'b1;
  endtask

  initial begin
    vecs[0] = '{4'd9,  4'd3,  1'b0, 5'b00110, 1'b1};
    vecs[1] = '{4'd3,  4'd9,  1'b0, 5'b11010, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 5'b11111, 1'b0};
    vecs[3] = '{4'd5,  4'd5,  1'b0, 5'b00000, 1'b0};
    vecs[4] = '{4'd15, 4'd0,  1'b1, 5'b01110, 1'b0};
    vecs[5] = '{4'd8,  4'd1,  1'b0, 5'b00111, 1'b1};
    vecs[6] = '{4'd7,  4'd15, 1'b0, 5'b11000, 1'b1};
    vecs[7] = '{4'd6,  4'd2,  1'b0, 5'b00100, 1'b0};
    vecs[8] = '{4'd15, 4'd15, 1'b1, 5'b11111, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset Diff", int'(Diff), 0);
`ifdef SUB_OVF_EN
    check("reset ovf", int'(ovf), 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single operations with full latency check.
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].bin);
      @(negedge clk);
      start = 1'b0;
      // Scramble inputs after acceptance; result must not change.
      a = ~vecs[i].a; b = ~vecs[i].b; bin = ~vecs[i].bin;
      for (int c = 1; c <= W; c++) begin
        check($sformatf("v%0d busy c%0d", i, c), int'(busy), 1);
        check($sformatf("v%0d done c%0d", i, c), int'(done), 0);
        @(negedge clk);
      end
      check_result($sformatf("v%0d", i), vecs[i].diff, vecs[i].ovf);
      @(negedge clk);
      check($sformatf("v%0d done drop", i), int'(done), 0);
      check($sformatf("v%0d idle busy", i), int'(busy), 0);
      check($sformatf("v%0d Diff held", i), int'(Diff), int'(vecs[i].diff));
    end

    // Back-to-back: second start held during the DONE cycle.
    launch(4'd5, 4'd5, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
    check_result("b2b first", 5'b00000, 1'b0);
    launch(4'd15, 4'd0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= W; c++) begin
      check($sformatf("b2b busy c%0d", c), int'(busy), 1);
      @(negedge clk);
    end
    check_result("b2b second", 5'b01110, 1'b0);
    @(negedge clk);

    // Start while busy must be ignored.
    launch(4'd9, 4'd3, 1'b0);
    @(negedge clk);            // cycle 1
    start = 1'b0;
    @(negedge clk);            // cycle 2
    launch(4'd1, 4'd1, 1'b0);
    @(negedge clk);            // cycle 3
    start = 1'b0;
    check("ignore busy c3", int'(busy), 1);
    repeat (2) @(negedge clk); // cycle 5
    check_result("ignore", 5'b00110, 1'b1);
    @(negedge clk);
    check("ignore no restart", int'(busy), 0);
    check("ignore single done", int'(done), 0);

    // Reset mid-operation aborts with no done pulse and clears Diff.
    launch(4'd3, 4'd9, 1'b0);
    @(negedge clk);            // cycle 1
    start = 1'b0;
    @(negedge clk);            // cycle 2
    reset = 1'b1;
    @(negedge clk);            // cycle 3
    reset = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort Diff", int'(Diff), 0);
    begin
      int seen = 0;
      for (int c = 0; c < 2 * W; c++) begin
        if (done) seen++;
        @(negedge clk);
      end
      check("abort no done", seen, 0);
    end
    check("abort Diff held", int'(Diff), 0);
    launch(4'd6, 4'd2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
    check_result("after abort", 5'b00100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
